// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : lifo_pkg
// Purpose: Shared types and sizing helpers for the parametrised LIFO.
//          - lifo_cnt_w(depth)     : width of the occupancy counter
//          - lifo_ram_depth(depth) : entries held in RAM (top two are regs)
//          - lifo_addr_w(depth)    : RAM address width (at least 1)
//          - op_e                  : operation decoded from {push, pop}
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package lifo_pkg;

  function automatic int lifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int lifo_ram_depth(input int depth);
    return depth - 2;
  endfunction

  function automatic int lifo_addr_w(input int depth);
    return (lifo_ram_depth(depth) > 2) ? $clog2(lifo_ram_depth(depth)) : 1;
  endfunction

  // Encoding matches the concatenation {push, pop} so a plain cast decodes it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

endpackage
`default_nettype wire

// File: rtl/lifo_ram.sv
`default_nettype none
// ============================================================================
// Module : lifo_ram
// Purpose: Single-port synchronous RAM, one-cycle read latency, write-first
//          (a write returns the written data on dout the next cycle).
// Ports  : clk  - clock
//          we   - write enable
//          addr - read/write address (ADDR_W bits)
//          din  - write data (WIDTH bits)
//          dout - registered read data (WIDTH bits)
// Rev    : 1.0 - initial release
// ============================================================================
module lifo_ram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  // Sized to the full address space so any address value stays in range.
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lifo_stack_param.sv
`default_nettype none
// ============================================================================
// Module : lifo_stack_param
// Purpose: Parametrised single-clock LIFO. The top two entries are held in
//          registers (top_q, next_q); deeper entries live in a sync-read RAM
//          whose address is kept pointing at the refill entry for next_q, so
//          back-to-back pops run without bubbles.
// Config : LIFO_ERR_FLAGS_EN - when defined, overflow/underflow are sticky
//          flags cleared by err_clr; otherwise they are tied low.
// Ports  : clk, rst (sync, active low), clr (sync flush)
//          push/push_data, pop -> pop_data/pop_valid (registered)
//          peek (top entry, 0 when empty), count, empty, full, almost_full
//          err_clr, overflow, underflow
// Rev    : 1.0 - initial release
// ============================================================================
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          pop_valid,
  output logic [WIDTH-1:0]              peek,
  output logic [lifo_cnt_w(DEPTH)-1:0]  count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          err_clr,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW     = lifo_cnt_w(DEPTH);
  localparam int ADDR_W = lifo_addr_w(DEPTH);

  logic [WIDTH-1:0]  top_q, next_q, ram_dout;
  logic [CW-1:0]     count_next;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              do_push, do_pop, do_repl, ovf_ev, unf_ev;
  op_e               op;

  assign op          = op_e'({push, pop});
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_THRESH));
  assign peek        = empty ? '0 : top_q;

  // Decode accepted operations and rejection events; clr suppresses both.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (rst && !clr) begin
      case (op)
        OP_PUSH: if (full) ovf_ev = 1'b1; else do_push = 1'b1;
        OP_POP:  if (empty) unf_ev = 1'b1; else do_pop = 1'b1;
        OP_REPL: begin
          if (empty) begin
            do_push = 1'b1;
            unf_ev  = 1'b1;
          end else begin
            do_repl = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_next = count;
    if (!rst || clr)  count_next = '0;
    else if (do_push) count_next = count + CW'(1);
    else if (do_pop)  count_next = count - CW'(1);
  end

  // Address = count_next-3: on a push this equals count-2 (the spill slot),
  // otherwise it pre-reads the entry that refills next_q on the next pop.
  assign ram_addr = ADDR_W'(count_next) - ADDR_W'(3);
  assign ram_we   = do_push && (count >= CW'(2));

  lifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (next_q),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count     <= '0;
      top_q     <= '0;
      next_q    <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      count     <= count_next;
      pop_valid <= do_pop || do_repl;
      if (do_push) begin
        next_q <= top_q;
        top_q  <= push_data;
      end
      if (do_pop) begin
        pop_data <= top_q;
        top_q    <= next_q;
        // RAM only holds a valid refill when a third entry exists.
        next_q   <= (count >= CW'(3)) ? ram_dout : '0;
      end
      if (do_repl) begin
        pop_data <= top_q;
        top_q    <= push_data;
      end
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  // A new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_ev)       overflow  <= 1'b1;
      else if (err_clr) overflow  <= 1'b0;
      if (unf_ev)       underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = err_clr ^ ovf_ev ^ unf_ev;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

endmodule
`default_nettype wire
